ucsbece154_icache: RTL and testbench

Set-associative, read-only instruction cache between the fetch stage and the burst-mode instruction memory. Fetch lookups that hit return an instruction one cycle after the request. A miss issues one block-read request to instruction memory, absorbs the returned beats into a victim way, and then answers the fetch. Optionally, the requested word is forwarded as soon as it arrives (critical-word-first).

---
 rtl/ucsbece154_icache_pkg.sv | 32 +++
 rtl/ucsbece154_icache_if.sv | 24 ++
 rtl/ucsbece154_icache_way.sv | 46 ++++
 rtl/ucsbece154_icache.sv | 174 +++++++++++++++++
 tb/tb_ucsbece154_icache.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ucsbece154_icache_pkg.sv
// rtl/ucsbece154_icache_pkg.sv - shared widths, width helpers and refill FSM states for the icache
package ucsbece154_icache_pkg;

    localparam int DEF_NUM_SETS    = 8;
    localparam int DEF_NUM_WAYS    = 4;
    localparam int DEF_BLOCK_WORDS = 4;

    function automatic int offset_width(int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int index_width(int num_sets);
        return $clog2(num_sets);
    endfunction

    // Byte-offset bits [1:0] never take part in the tag.
    function automatic int tag_width(int num_sets, int block_words);
        return 30 - $clog2(num_sets) - $clog2(block_words);
    endfunction

    localparam int OFFSET_W = offset_width(DEF_BLOCK_WORDS);
    localparam int INDEX_W  = index_width(DEF_NUM_SETS);
    localparam int TAG_W    = tag_width(DEF_NUM_SETS, DEF_BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/ucsbece154_icache_if.sv
// rtl/ucsbece154_icache_if.sv - fetch-side and instruction-memory-side signals of the icache
interface ucsbece154_icache_if;

    logic        ReadEnable;
    logic [31:0] ReadAddress;
    logic [31:0] Instruction;
    logic        Ready;
    logic        Busy;
    logic        MemReadRequest;
    logic [31:0] MemReadAddress;
    logic [31:0] MemDataIn;
    logic        MemDataReady;

    modport slave (
        input  ReadEnable, ReadAddress, MemDataIn, MemDataReady,
        output Instruction, Ready, Busy, MemReadRequest, MemReadAddress
    );

    modport master (
        output ReadEnable, ReadAddress, MemDataIn, MemDataReady,
        input  Instruction, Ready, Busy, MemReadRequest, MemReadAddress
    );

endinterface

// File: rtl/ucsbece154_icache_way.sv
// rtl/ucsbece154_icache_way.sv - one cache way: valid/tag/data per set, async lookup, whole-line write
module ucsbece154_icache_way
    import ucsbece154_icache_pkg::*;
#(
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int TAG_W       = tag_width(DEF_NUM_SETS, DEF_BLOCK_WORDS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [index_width(NUM_SETS)-1:0]      rd_index,
    input  logic [offset_width(BLOCK_WORDS)-1:0]  rd_offset,
    output logic                                  rd_valid,
    output logic [TAG_W-1:0]                      rd_tag,
    output logic [31:0]                           rd_word,
    input  logic                                  wr_en,
    input  logic [index_width(NUM_SETS)-1:0]      wr_index,
    input  logic [TAG_W-1:0]                      wr_tag,
    input  logic [BLOCK_WORDS-1:0][31:0]          wr_line
);

    logic [NUM_SETS-1:0]          valid;
    logic [TAG_W-1:0]             tags  [NUM_SETS];
    logic [BLOCK_WORDS-1:0][31:0] lines [NUM_SETS];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_word  = lines[rd_index][rd_offset];

    // Only valid bits need reset; tag/data are ignored until valid is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_line;
        end
    end

endmodule

// File: rtl/ucsbece154_icache.sv
// rtl/ucsbece154_icache.sv - set-associative read-only icache with burst refill FSM
// ICACHE_CWF_EN: critical-word-first request, wrapped fill and early forwarding of the requested word.
module ucsbece154_icache
    import ucsbece154_icache_pkg::*;
#(
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int NUM_WAYS    = DEF_NUM_WAYS,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
    input  logic               clk,
    input  logic               reset,
    ucsbece154_icache_if.slave bus
);

    localparam int OW = offset_width(BLOCK_WORDS);
    localparam int IW = index_width(NUM_SETS);
    localparam int TW = tag_width(NUM_SETS, BLOCK_WORDS);
    localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    state_t                       state, state_n;
    logic [31:0]                  lat_addr;
    logic [OW:0]                  beat_cnt;
    logic [BLOCK_WORDS-1:0][31:0] fill_buf;
    logic [WW-1:0]                rr_ptr [NUM_SETS];
    logic                         ready_q;
    logic [31:0]                  instr_q;

    logic [29:0]                  req_word;
    logic [IW-1:0]                lk_index;
    logic [OW-1:0]                lk_off;
    logic [TW-1:0]                lk_tag;
    logic [OW-1:0]                lat_wo;
    logic [OW-1:0]                fill_pos;
    logic                         last_beat;

    logic [NUM_WAYS-1:0]          way_valid;
    logic [NUM_WAYS-1:0]          way_we;
    logic [TW-1:0]                way_tag  [NUM_WAYS];
    logic [31:0]                  way_word [NUM_WAYS];
    logic                         hit;
    logic [31:0]                  hit_word;
    logic [WW-1:0]                victim;

    // Outside IDLE the lookup port serves the latched miss set, so victim selection sees it at COMMIT.
    assign req_word  = (state == IDLE) ? bus.ReadAddress[31:2] : lat_addr[31:2];
    assign lk_off    = req_word[0 +: OW];
    assign lk_index  = req_word[OW +: IW];
    assign lk_tag    = req_word[29 -: TW];
    assign lat_wo    = lat_addr[2 +: OW];
    assign last_beat = bus.MemDataReady && (beat_cnt == (OW+1)'(BLOCK_WORDS - 1));

`ifdef ICACHE_CWF_EN
    assign fill_pos = lat_wo + beat_cnt[OW-1:0];
`else
    assign fill_pos = beat_cnt[OW-1:0];
`endif

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign way_we[w] = (state == COMMIT) && (victim == WW'(w));

        ucsbece154_icache_way #(
            .NUM_SETS    (NUM_SETS),
            .BLOCK_WORDS (BLOCK_WORDS),
            .TAG_W       (TW)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .rd_index  (lk_index),
            .rd_offset (lk_off),
            .rd_valid  (way_valid[w]),
            .rd_tag    (way_tag[w]),
            .rd_word   (way_word[w]),
            .wr_en     (way_we[w]),
            .wr_index  (lk_index),
            .wr_tag    (lk_tag),
            .wr_line   (fill_buf)
        );
    end

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_valid[w] && (way_tag[w] == lk_tag)) begin
                hit      = 1'b1;
                hit_word = way_word[w];
            end
        end
    end

    // Descending scan leaves the lowest-indexed invalid way; round-robin only when the set is full.
    always_comb begin
        victim = rr_ptr[lk_index];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim = WW'(w);
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.ReadEnable && !hit) state_n = REQ;
            REQ:     state_n = FILL;
            FILL:    if (last_beat) state_n = COMMIT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lat_addr <= '0;
            beat_cnt <= '0;
            ready_q  <= 1'b0;
            instr_q  <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else begin
            state   <= state_n;
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (bus.ReadEnable) begin
                        if (hit) begin
                            ready_q <= 1'b1;
                            instr_q <= hit_word;
                        end else begin
                            lat_addr <= bus.ReadAddress;
                        end
                    end
                end
                FILL: begin
                    if (bus.MemDataReady) begin
                        beat_cnt <= beat_cnt + (OW+1)'(1);
`ifdef ICACHE_CWF_EN
                        if (beat_cnt == '0) begin
                            ready_q <= 1'b1;
                            instr_q <= bus.MemDataIn;
                        end
`endif
                    end
                end
                COMMIT: rr_ptr[lk_index] <= rr_ptr[lk_index] + WW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == FILL) && bus.MemDataReady) begin
            fill_buf[fill_pos] <= bus.MemDataIn;
        end
    end

    assign bus.Busy           = (state != IDLE);
    assign bus.MemReadRequest = (state == REQ);

`ifdef ICACHE_CWF_EN
    assign bus.MemReadAddress = (state == REQ) ? (lat_addr & ~32'h3) : '0;
    assign bus.Ready          = ready_q;
    assign bus.Instruction    = instr_q;
`else
    localparam logic [31:0] BLOCK_MASK = ~((32'(BLOCK_WORDS) << 2) - 32'd1);
    assign bus.MemReadAddress = (state == REQ) ? (lat_addr & BLOCK_MASK) : '0;
    assign bus.Ready          = ready_q | (state == COMMIT);
    assign bus.Instruction    = (state == COMMIT) ? fill_buf[lat_wo] : instr_q;
`endif

endmodule

// File: tb/tb_ucsbece154_icache.sv
// tb/tb_ucsbece154_icache.sv - directed self-checking bench for ucsbece154_icache with a burst memory model
module tb_ucsbece154_icache;

    localparam logic [31:0] TEXT_BASE = 32'h0001_0000;
`ifdef ICACHE_CWF_EN
    localparam int MISS_CYC = 3;
    localparam int FWD_T    = 3;
`else
    localparam int MISS_CYC = 6;
    localparam int FWD_T    = 6;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ucsbece154_icache_if bus();

    ucsbece154_icache dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          req_cnt      = 0;
    logic [31:0] req_addr     = '0;
    bit          sending      = 1'b0;
    int          beat_k       = 0;
    logic        obs_ready;
    logic [31:0] obs_instr;
    logic        obs_mreq;
    logic [31:0] obs_maddr;

    function automatic logic [31:0] text_word(input logic [31:0] a);
        return 32'hA000_0000 + ((a - TEXT_BASE) >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the negedge, then act as memory (beats start the cycle after the request).
    task automatic tick();
        logic [31:0] blk;
        logic [1:0]  wo;
        @(posedge clk);
        @(negedge clk);
        obs_ready = bus.Ready;
        obs_instr = bus.Instruction;
        obs_mreq  = bus.MemReadRequest;
        obs_maddr = bus.MemReadAddress;
        if (sending && beat_k < 4) begin
            blk = req_addr & ~32'hF;
            wo  = req_addr[3:2];
            bus.MemDataReady = 1'b1;
            bus.MemDataIn    = text_word(blk + {28'd0, wo + 2'(beat_k), 2'b00});
            beat_k++;
        end else begin
            bus.MemDataReady = 1'b0;
            bus.MemDataIn    = '0;
            sending          = 1'b0;
        end
        if (obs_mreq) begin
            req_cnt++;
            req_addr = obs_maddr;
            sending  = 1'b1;
            beat_k   = 0;
        end
    endtask

    task automatic fetch(input logic [31:0] addr, output logic [31:0] data, output int cycles);
        bus.ReadEnable  = 1'b1;
        bus.ReadAddress = addr;
        data   = '0;
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (obs_ready) begin
                data   = obs_instr;
                cycles = i;
                break;
            end
        end
        bus.ReadEnable = 1'b0;
    endtask

    task automatic drain(input int n, output int extra);
        extra = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (obs_ready) extra++;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] instr_at [9];
        int          cyc;
        int          n0;
        int          extra;
        int          mask;

        reset            = 1'b1;
        bus.ReadEnable   = 1'b0;
        bus.ReadAddress  = '0;
        bus.MemDataIn    = '0;
        bus.MemDataReady = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.Ready), 32'd0);
        check("rst_instr", bus.Instruction, 32'd0);
        check("rst_busy",  32'(bus.Busy), 32'd0);
        check("rst_mreq",  32'(bus.MemReadRequest), 32'd0);
        check("rst_maddr", bus.MemReadAddress, 32'd0);
        reset = 1'b0;

        // First miss loads block 0x00010000 into way 0 of set 0.
        n0 = req_cnt;
`ifdef ICACHE_CWF_EN
        fetch(32'h0001_0008, d, cyc);
        check("cwf_data",     d, 32'hA000_0002);
        check("cwf_cycles",   32'(cyc), 32'd3);
        check("cwf_req_addr", req_addr, 32'h0001_0008);
        check("cwf_req_cnt",  32'(req_cnt - n0), 32'd1);
        drain(5, extra);
        check("cwf_single_ready", 32'(extra), 32'd0);
        fetch(32'h0001_0000, d, cyc);
        check("cwf_hit_data",   d, 32'hA000_0000);
        check("cwf_hit_cycles", 32'(cyc), 32'd1);
        check("cwf_hit_noreq",  32'(req_cnt - n0), 32'd1);
        drain(1, extra);
`else
        fetch(32'h0001_0000, d, cyc);
        check("cold_data",     d, 32'hA000_0000);
        check("cold_cycles",   32'(cyc), 32'd6);
        check("cold_req_addr", req_addr, 32'h0001_0000);
        check("cold_req_cnt",  32'(req_cnt - n0), 32'd1);
        drain(2, extra);
        check("cold_single_ready", 32'(extra), 32'd0);
`endif

        n0 = req_cnt;
        fetch(32'h0001_0004, d, cyc);
        check("hit_data",   d, 32'hA000_0001);
        check("hit_cycles", 32'(cyc), 32'd1);
        check("hit_noreq",  32'(req_cnt - n0), 32'd0);
        drain(1, extra);

        n0 = req_cnt;
        bus.ReadEnable  = 1'b1;
        bus.ReadAddress = 32'h0001_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_ready", 32'(obs_ready), 32'd1);
            check("stream_data",  obs_instr, 32'hA000_0000 + 32'(i));
            if (i < 3) bus.ReadAddress = 32'h0001_0000 + 32'(4 * (i + 1));
            else       bus.ReadEnable  = 1'b0;
        end
        check("stream_noreq", 32'(req_cnt - n0), 32'd0);
        drain(1, extra);

        // Four more lines into set 0: the fifth occupant evicts block 0x00010000.
        for (int k = 1; k <= 4; k++) begin
            n0 = req_cnt;
            fetch(32'h0001_0000 + 32'(k * 32'h80), d, cyc);
            check("evict_fill_data", d, text_word(32'h0001_0000 + 32'(k * 32'h80)));
            check("evict_fill_miss", 32'(req_cnt - n0), 32'd1);
            drain(5, extra);
        end
        n0 = req_cnt;
        fetch(32'h0001_0180, d, cyc);
        check("evict_k3_hit",   d, 32'hA000_0060);
        check("evict_k3_noreq", 32'(req_cnt - n0), 32'd0);
        drain(1, extra);
        fetch(32'h0001_0000, d, cyc);
        check("evict_k0_miss",     32'(req_cnt - n0), 32'd1);
        check("evict_k0_data",     d, 32'hA000_0000);
        check("evict_k0_cycles",   32'(cyc), 32'(MISS_CYC));
        check("evict_k0_req_addr", req_addr, 32'h0001_0000);
        drain(5, extra);
        n0 = req_cnt;
        fetch(32'h0001_0100, d, cyc);
        check("evict_k2_hit",   d, 32'hA000_0040);
        check("evict_k2_noreq", 32'(req_cnt - n0), 32'd0);
        drain(1, extra);

        // Switch to a cached address during the refill; it is looked up only after COMMIT.
        n0   = req_cnt;
        mask = 0;
        bus.ReadEnable  = 1'b1;
        bus.ReadAddress = 32'h0001_0010;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (obs_ready) mask = mask | (1 << t);
            instr_at[t] = obs_instr;
            if (t == 2) bus.ReadAddress = 32'h0001_0004;
            if (t == 8) bus.ReadEnable  = 1'b0;
        end
        check("fill_ready_mask", 32'(mask), 32'((1 << FWD_T) | (1 << 8)));
        check("fill_miss_data",  instr_at[FWD_T], 32'hA000_0004);
        check("fill_hit_data",   instr_at[8], 32'hA000_0001);
        check("fill_req_cnt",    32'(req_cnt - n0), 32'd1);
        drain(2, extra);

        // Reset after beat 1 of a refill: nothing committed, the line misses again.
        n0 = req_cnt;
        bus.ReadEnable  = 1'b1;
        bus.ReadAddress = 32'h0001_0040;
        repeat (4) tick();
        reset            = 1'b1;
        bus.ReadEnable   = 1'b0;
        bus.MemDataReady = 1'b0;
        sending          = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.Ready), 32'd0);
        check("midrst_instr", bus.Instruction, 32'd0);
        check("midrst_busy",  32'(bus.Busy), 32'd0);
        check("midrst_mreq",  32'(bus.MemReadRequest), 32'd0);
        check("midrst_maddr", bus.MemReadAddress, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("midrst_req_cnt", 32'(req_cnt - n0), 32'd1);
        fetch(32'h0001_0040, d, cyc);
        check("midrst_remiss",   32'(req_cnt - n0), 32'd2);
        check("midrst_data",     d, 32'hA000_0010);
        check("midrst_cycles",   32'(cyc), 32'(MISS_CYC));
        check("midrst_req_addr", req_addr, 32'h0001_0040);
        drain(5, extra);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
